// File: rtl/merge2_stage_if.sv
// ============================================================================
// Module   : merge2_stage_if
// Brief    : Bundle of the two upstream FIFO read ports (A, B) and the merged
//            output stream of the two-way merge stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface merge2_stage_if #(
  parameter int DATA_WIDTH = 32
);
  // Upstream FIFO A read side
  logic [DATA_WIDTH-1:0] a_dcmp;
  logic                  a_empty;
  logic                  a_rd_en;
  // Upstream FIFO B read side
  logic [DATA_WIDTH-1:0] b_dcmp;
  logic                  b_empty;
  logic                  b_rd_en;
  // Downstream stream
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  busy;

  // Environment side: owns the FIFOs and the downstream sink
  modport master (
    output a_dcmp, a_empty, b_dcmp, b_empty, out_ready,
    input  a_rd_en, b_rd_en, out_data, out_valid, out_last, busy
  );

  // Merge stage side
  modport slave (
    input  a_dcmp, a_empty, b_dcmp, b_empty, out_ready,
    output a_rd_en, b_rd_en, out_data, out_valid, out_last, busy
  );
endinterface

`default_nettype wire

// File: rtl/merge2_stage.sv
// ============================================================================
// Module   : merge2_stage
// Brief    : Two-way merge stage of the merge-sort pipeline. Merges run k of
//            FIFO A with run k of FIFO B (RUN_LEN words each) into one sorted
//            run of 2*RUN_LEN words. Heads are peeked, pops are combinational,
//            the merged word is registered one cycle after its pop.
// Config   : MERGE_DESCEND_EN - when defined, merge in descending order
//            (A wins when a_dcmp >= b_dcmp). Default is ascending (A wins
//            when a_dcmp <= b_dcmp). Ties always go to A.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module merge2_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int RUN_LEN    = 4
) (
  input  logic           clk,
  input  logic           reset,
  merge2_stage_if.slave  bus
);

  // Counter must hold the value RUN_LEN itself, hence the extra bit.
  localparam int CNT_W = $clog2(RUN_LEN) + 1;

  localparam logic [CNT_W-1:0] c_run_len = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  localparam logic [1:0] c_st_merge   = 2'd0;
  localparam logic [1:0] c_st_drain_a = 2'd1;
  localparam logic [1:0] c_st_drain_b = 2'd2;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt_a;
  logic [CNT_W-1:0]      r_cnt_b;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;

  logic                  w_a_first;
  logic                  w_pop_a;
  logic                  w_pop_b;
  logic [CNT_W-1:0]      w_cnt_a_inc;
  logic [CNT_W-1:0]      w_cnt_b_inc;
  logic                  w_a_done;
  logic                  w_b_done;
  logic                  w_run_end;
  logic [1:0]            w_state_nxt;

  // Only the comparator differs between the two sort directions; unsigned
  // full-width compare, ties resolved towards A to keep the merge stable.
`ifdef MERGE_DESCEND_EN
  assign w_a_first = (bus.a_dcmp >= bus.b_dcmp);
`else
  assign w_a_first = (bus.a_dcmp <= bus.b_dcmp);
`endif

  assign w_cnt_a_inc = r_cnt_a + c_one;
  assign w_cnt_b_inc = r_cnt_b + c_one;
  assign w_a_done    = (w_cnt_a_inc == c_run_len);
  assign w_b_done    = (w_cnt_b_inc == c_run_len);

  // The run closes when the draining side delivers its final word.
  assign w_run_end = ((r_state == c_st_drain_a) && w_pop_a && w_a_done) ||
                     ((r_state == c_st_drain_b) && w_pop_b && w_b_done);

  // Pop selection: in MERGE both heads must be present (never guess), in a
  // drain state only the side still holding words is considered.
  always_comb begin
    w_pop_a = 1'b0;
    w_pop_b = 1'b0;
    case (r_state)
      c_st_merge: begin
        if (bus.out_ready && !bus.a_empty && !bus.b_empty) begin
          w_pop_a = w_a_first;
          w_pop_b = !w_a_first;
        end
      end
      c_st_drain_a: w_pop_a = bus.out_ready && !bus.a_empty;
      c_st_drain_b: w_pop_b = bus.out_ready && !bus.b_empty;
      default: begin
        w_pop_a = 1'b0;
        w_pop_b = 1'b0;
      end
    endcase
  end

  // Next-state: exhausting one side in MERGE switches to draining the other;
  // an unused encoding falls back to MERGE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_merge: begin
        if (w_pop_a && w_a_done) begin
          w_state_nxt = c_st_drain_b;
        end else if (w_pop_b && w_b_done) begin
          w_state_nxt = c_st_drain_a;
        end
      end
      c_st_drain_a: w_state_nxt = c_st_drain_a;
      c_st_drain_b: w_state_nxt = c_st_drain_b;
      default:      w_state_nxt = c_st_merge;
    endcase
  end

  // State, per-side counters and the registered output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_st_merge;
      r_cnt_a     <= '0;
      r_cnt_b     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= w_pop_a || w_pop_b;
      r_out_last  <= w_run_end;
      if (w_pop_a) begin
        r_out_data <= bus.a_dcmp;
      end else if (w_pop_b) begin
        r_out_data <= bus.b_dcmp;
      end
      if (w_run_end) begin
        r_cnt_a <= '0;
        r_cnt_b <= '0;
        r_state <= c_st_merge;
      end else begin
        if (w_pop_a) begin
          r_cnt_a <= w_cnt_a_inc;
        end
        if (w_pop_b) begin
          r_cnt_b <= w_cnt_b_inc;
        end
        r_state <= w_state_nxt;
      end
    end
  end

  assign bus.a_rd_en   = w_pop_a;
  assign bus.b_rd_en   = w_pop_b;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_cnt_a != '0) || (r_cnt_b != '0);

endmodule

`default_nettype wire
